// File: rtl/alu_package.sv
// alu_package: shared ALU types and widths.
// Provides opcode_e, the driver FSM state enum, operand/result widths
// and the packed command record carried through the driver's FIFO.
package alu_package;
    localparam int OPND_W = 4;
    localparam int RES_W  = 5;
    typedef enum logic [1:0] {ADD, SUB, AND, OR} opcode_e;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} alu_drv_state_e;
    typedef struct packed {
        opcode_e                   op;
        logic signed [OPND_W-1:0]  a;
        logic signed [OPND_W-1:0]  b;
    } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command buffer with wrapping pointers and occupancy count.
// Ports: clk, rst (async, active-low), push/din write side, pop/dout read side
// (dout shows the head entry), full/empty status decoded from the count.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_en, rd_en;
    assign full  = count == FULL_CNT;
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/alu_driver.sv
// alu_driver: buffers ALU requests, issues them one at a time, returns tagged results.
// Ports: clk, rst (async, active-low); cmd_* request stream (cmd_ready = FIFO not full);
// rsp_* response stream (rsp_err = result mismatch flag); alu_en/alu_a/alu_b/alu_op to
// the ALU and alu_c back from it (valid the cycle after alu_en).
// Build option: define ALU_DRV_CHECK_EN to build the result-checking model for rsp_err;
// otherwise rsp_err is tied to 0.
module alu_driver
    import alu_package::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic signed [OPND_W-1:0] cmd_a,
    input  logic signed [OPND_W-1:0] cmd_b,
    input  opcode_e                  cmd_op,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic signed [RES_W-1:0]  rsp_c,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic                     alu_en,
    output logic signed [OPND_W-1:0] alu_a,
    output logic signed [OPND_W-1:0] alu_b,
    output opcode_e                  alu_op,
    input  logic signed [RES_W-1:0]  alu_c
);
    localparam int PW = $bits(alu_cmd_t) + TAG_W;
    alu_drv_state_e   state;
    alu_cmd_t         head_cmd;
    logic [TAG_W-1:0] head_tag, tag_q;
    logic [PW-1:0]    head;
    logic             full, empty, pop;
    assign cmd_ready = !full;
    assign {head_cmd, head_tag} = head;
    // The next command is taken when idle, or straight out of RESP on the handshake
    // so back-to-back operations need no IDLE cycle.
    assign pop = !empty && (state == IDLE || (state == RESP && rsp_ready));
    alu_cmd_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   ({cmd_op, cmd_a, cmd_b, cmd_tag}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            alu_en    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= ADD;
            tag_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_c     <= '0;
            rsp_tag   <= '0;
        end else begin
            if (pop) begin
                alu_a  <= head_cmd.a;
                alu_b  <= head_cmd.b;
                alu_op <= head_cmd.op;
                tag_q  <= head_tag;
            end
            alu_en <= pop;
            case (state)
                IDLE:  state <= pop ? ISSUE : IDLE;
                ISSUE: state <= WAIT;
                WAIT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_c     <= alu_c;
                    rsp_tag   <= tag_q;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= pop ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ALU_DRV_CHECK_EN
    logic signed [RES_W-1:0] ea, eb, exp_c;
    assign ea = {alu_a[OPND_W-1], alu_a};
    assign eb = {alu_b[OPND_W-1], alu_b};
    assign exp_c = alu_op == ADD ? ea + eb :
                   alu_op == SUB ? ea - eb :
                   alu_op == AND ? ea & eb :
                   alu_op == OR  ? ea | eb : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rsp_err <= 1'b0;
        else if (state == WAIT) rsp_err <= alu_c != exp_c;
    end
`else
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: self-checking bench for alu_driver with a behavioural ALU attached.
module tb_alu_driver;
    import alu_package::*;
`ifdef ALU_DRV_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    typedef struct {
        opcode_e op;
        int      a;
        int      b;
        int      tag;
        int      c;
        int      err;
    } vec_t;
    typedef struct {
        int c;
        int tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, alu_en;
    logic signed [3:0] cmd_a, cmd_b, alu_a, alu_b;
    opcode_e           cmd_op, alu_op;
    logic [1:0]        cmd_tag, rsp_tag, tag_ctr;
    logic signed [4:0] rsp_c, alu_c, alu_r;
    logic              force_zero;
    int                checks = 0;
    int                failures = 0;
    exp_t              exp_q[$];
    vec_t              vecs[7];

    always #5 clk = ~clk;

    alu_driver dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .cmd_tag   (cmd_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .alu_en    (alu_en),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c)
    );

    function automatic int model_c(opcode_e op, int a, int b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            default: return 0;
        endcase
    endfunction

    // Sequential ALU: result appears on C the cycle after en.
    always @(posedge clk) if (alu_en) alu_r <= 5'(model_c(alu_op, int'(alu_a), int'(alu_b)));
    assign alu_c = force_zero ? 5'sd0 : alu_r;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic take_rsp(input string nm);
        exp_t e;
        if (exp_q.size() == 0) check({nm, "_unexpected_rsp"}, int'(rsp_valid), 0);
        else begin
            e = exp_q.pop_front();
            check({nm, "_c"}, int'(rsp_c), e.c);
            check({nm, "_tag"}, int'(rsp_tag), e.tag);
            check({nm, "_err"}, int'(rsp_err), 0);
        end
    endtask

    task automatic send_one(input vec_t v, input string nm);
        cmd_valid = 1'b1;
        cmd_op = v.op;
        cmd_a = 4'(v.a);
        cmd_b = 4'(v.b);
        cmd_tag = 2'(v.tag);
        check({nm, "_ready"}, int'(cmd_ready), 1);
        tick;
        cmd_valid = 1'b0;
        check({nm, "_en_t1"}, int'(alu_en), 0);
        tick;
        check({nm, "_en_t2"}, int'(alu_en), 1);
        check({nm, "_alu_a"}, int'(alu_a), v.a);
        check({nm, "_alu_b"}, int'(alu_b), v.b);
        check({nm, "_alu_op"}, int'(alu_op), int'(v.op));
        tick;
        check({nm, "_en_t3"}, int'(alu_en), 0);
        check({nm, "_vld_t3"}, int'(rsp_valid), 0);
        tick;
        check({nm, "_vld_t4"}, int'(rsp_valid), 1);
        check({nm, "_c"}, int'(rsp_c), v.c);
        check({nm, "_tag"}, int'(rsp_tag), v.tag);
        check({nm, "_err"}, int'(rsp_err), v.err);
        tick;
        check({nm, "_vld_hold"}, int'(rsp_valid), 1);
        check({nm, "_c_hold"}, int'(rsp_c), v.c);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check({nm, "_vld_done"}, int'(rsp_valid), 0);
    endtask

    task automatic push_rand;
        cmd_op = opcode_e'($urandom_range(3));
        cmd_a = 4'($urandom_range(15));
        cmd_b = 4'($urandom_range(15));
        cmd_tag = tag_ctr;
    endtask

    task automatic run_stream(input int cycles, input int vpct, input int rpct, input bit gap_chk);
        int  last = -1;
        bit  prev_en = 1'b0;
        for (int n = 0; n < cycles + 300 && (n < cycles || exp_q.size() > 0); n++) begin
            push_rand();
            cmd_valid = (n < cycles) && ($urandom_range(99) < vpct);
            rsp_ready = $urandom_range(99) < rpct;
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back('{c: model_c(cmd_op, int'(cmd_a), int'(cmd_b)), tag: int'(tag_ctr)});
                tag_ctr++;
            end
            if (rsp_valid && rsp_ready) begin
                take_rsp("stream");
                if (gap_chk && last >= 0) check("rsp_gap", n - last, 3);
                last = n;
            end
            if (gap_chk && alu_en) check("en_back_to_back", int'(prev_en), 0);
            prev_en = alu_en;
            tick;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("stream_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{op: ADD, a:  3, b:  4, tag: 1, c:   7, err: 0};
        vecs[1] = '{op: ADD, a:  7, b:  7, tag: 2, c:  14, err: 0};
        vecs[2] = '{op: SUB, a: -8, b:  7, tag: 3, c: -15, err: 0};
        vecs[3] = '{op: AND, a: -1, b:  5, tag: 0, c:   5, err: 0};
        vecs[4] = '{op: OR,  a: -8, b:  3, tag: 1, c:  -5, err: 0};
        vecs[5] = '{op: SUB, a:  7, b: -8, tag: 2, c:  15, err: 0};
        vecs[6] = '{op: ADD, a: -8, b: -8, tag: 3, c: -16, err: 0};
        rst = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = ADD;
        cmd_tag = '0;
        tag_ctr = '0;
        force_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_c", int'(rsp_c), 0);
        check("rst_rsp_tag", int'(rsp_tag), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        check("rst_alu_en", int'(alu_en), 0);
        check("rst_alu_a", int'(alu_a), 0);
        check("rst_alu_b", int'(alu_b), 0);
        check("rst_alu_op", int'(alu_op), int'(ADD));
        rst = 1'b1;
        tick;
        tick;

        for (int i = 0; i < 7; i++) send_one(vecs[i], $sformatf("vec%0d", i));

        force_zero = 1'b1;
        send_one('{op: ADD, a: 2, b: 2, tag: 0, c: 0, err: CHK}, "mismatch");
        force_zero = 1'b0;

        // Back-pressure: one in RESP, four buffered, sixth attempt refused.
        tag_ctr = '0;
        for (int i = 0; i < 5; i++) begin
            push_rand();
            cmd_valid = 1'b1;
            check("bp_ready", int'(cmd_ready), 1);
            exp_q.push_back('{c: model_c(cmd_op, int'(cmd_a), int'(cmd_b)), tag: int'(tag_ctr)});
            tag_ctr++;
            tick;
        end
        push_rand();
        check("bp_full_ready", int'(cmd_ready), 0);
        check("bp_in_resp", int'(rsp_valid), 1);
        tick;
        cmd_valid = 1'b0;
        repeat (3) tick;
        check("bp_still_full", int'(cmd_ready), 0);
        rsp_ready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
            if (rsp_valid) take_rsp("bp");
            tick;
        end
        check("bp_all_returned", exp_q.size(), 0);
        exp_q.delete();
        for (int n = 0; n < 6; n++) begin
            check("bp_no_extra", int'(rsp_valid), 0);
            tick;
        end
        rsp_ready = 1'b0;

        run_stream(45, 100, 100, 1'b1);
        run_stream(300, 60, 60, 1'b0);
        tick;

        // Reset during WAIT with two commands still queued.
        for (int i = 0; i < 3; i++) begin
            push_rand();
            cmd_valid = 1'b1;
            tick;
            if (i == 1) check("mr_issue_en", int'(alu_en), 1);
        end
        cmd_valid = 1'b0;
        check("mr_wait_en", int'(alu_en), 0);
        check("mr_wait_vld", int'(rsp_valid), 0);
        rst = 1'b0;
        #1;
        check("mr_rst_ready", int'(cmd_ready), 1);
        check("mr_rst_en", int'(alu_en), 0);
        check("mr_rst_vld", int'(rsp_valid), 0);
        tick;
        tick;
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            check("mr_no_rsp", int'(rsp_valid), 0);
            check("mr_no_en", int'(alu_en), 0);
            check("mr_ready", int'(cmd_ready), 1);
            tick;
        end
        rsp_ready = 1'b0;
        send_one('{op: SUB, a: 5, b: 3, tag: 2, c: 2, err: 0}, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_driver.md
# alu_driver

Command-side initiator for the sequential ALU. Accepts operation requests on a valid/ready stream and buffers them in a small FIFO. Issues them one at a time to the ALU through its `en`/`opcode`/`A`/`B` inputs, captures the registered result, and returns it with the request tag on a valid/ready response stream. It sits between the test/host command source and the ALU instance.

## Interface
- `DEPTH`, default 4: command FIFO depth; power of two, ≥2.
- `TAG_W`, default 2: request tag width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  request valid.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_a`, `cmd_b`  in  4 signed  operands.
- `cmd_op`  in  `opcode_e`  operation.
- `cmd_tag`  in  TAG_W  request tag.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accepted.
- `rsp_c`  out  5 signed  ALU result.
- `rsp_tag`  out  TAG_W  tag of the originating request.
- `rsp_err`  out  1  result mismatch flag (see Configuration).
- `alu_en`  out  1  to ALU `en`.
- `alu_a`, `alu_b`  out  4 signed  to ALU `A`/`B`.
- `alu_op`  out  `opcode_e`  to ALU `opcode`.
- `alu_c`  in  5 signed  from ALU `C`.

## Operation
- Push when `cmd_valid && cmd_ready`. `cmd_ready = !full`; it does not depend on a same-cycle pop.
- FIFO uses `DEPTH` entries and wrapping read/write pointers plus an occupancy counter (0..DEPTH). A simultaneous push and pop leaves the count unchanged.
- FSM, one outstanding operation:
  - IDLE: if FIFO not empty → ISSUE. On the transition, pop the head into the `alu_a`/`alu_b`/`alu_op` registers and the tag into a held register.
  - ISSUE: `alu_en`=1 for exactly this cycle → WAIT.
  - WAIT: `alu_en`=0; the ALU result becomes valid on `alu_c` this cycle. Capture `alu_c` into `rsp_c` at the end of the cycle → RESP.
  - RESP: `rsp_valid`=1 and holds with `rsp_c`/`rsp_tag`/`rsp_err` stable until `rsp_ready`. On handshake go to IDLE, or go directly to ISSUE with the next pop if the FIFO is non-empty.
- `alu_a`/`alu_b`/`alu_op` hold their last values while `alu_en`=0.
- Responses return in request order.
- Reset values: `cmd_ready`=1 (FIFO empty), `rsp_valid`=0, `rsp_c`=0, `rsp_tag`=0, `rsp_err`=0, `alu_en`=0, `alu_a`=0, `alu_b`=0, `alu_op`=`ADD`. FSM resets to IDLE; pointers and count reset to 0.
- Reset asserted mid-operation flushes the FIFO and any in-flight operation. Nothing is replayed.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from the count register.
- Latency: the command is pushed in cycle T. With an empty FIFO and idle FSM, `alu_en`=1 in T+2 and `rsp_valid`=1 in T+4.
- Back-to-back commands with `rsp_ready` tied high: one result every 3 cycles (ISSUE, WAIT, RESP).
- `rsp_ready` held low stalls the FSM in RESP. The FIFO keeps accepting until full, then `cmd_ready`=0.

## Configuration
- `ALU_DRV_CHECK_EN` defined: a built-in model computes the expected result from the held operands and opcode. Both operands are sign-extended to 5 bits, then:
  - `ADD`: a+b
  - `SUB`: a−b
  - `AND`: a&b
  - `OR`: a|b
  - any other encoding: 0
- `rsp_err` is registered alongside `rsp_c` and equals `(alu_c != expected)`.
- Undefined: no model is built and `rsp_err` is tied to 0.

## Structure
- `opcode_e` (`ADD`, `SUB`, `AND`, `OR`) comes from `alu_package`.
- Add the driver FSM state enum `alu_drv_state_e` (IDLE, ISSUE, WAIT, RESP) to `alu_package`.
- Add the operand/result width constants (4, 5) to `alu_package`.
- One sub-module, `alu_cmd_fifo` (parameterised DEPTH and payload width), holds the command buffer. The FSM, ALU-side registers and check model live in `alu_driver`.

## Test plan
- Reset: `rst` low → all outputs at reset values. Release, then push `ADD` a=3 b=4 tag=1 → `alu_en` pulse one cycle at T+2; `rsp_valid` at T+4 with `rsp_c`=7, `rsp_tag`=1.
- Arithmetic edges (ALU attached, check enabled): `ADD` 7+7 → 14; `SUB` −8−7 → −15; `AND` −1&5 → 5; `OR` −8|3 → −5; `rsp_err`=0 throughout.
- Back-pressure: hold `rsp_ready`=0 and push 5 commands (DEPTH=4) → 1 in RESP, 4 buffered, `cmd_ready`=0 on the 6th attempt. Release `rsp_ready` → 5 in-order responses, tags 0,1,2,3,0.
- Throughput: `rsp_ready`=1 and a continuous command stream → `rsp_valid` pulses exactly every 3 cycles, with `alu_en` never high two consecutive cycles.
- Mismatch (check enabled): force `alu_c`=0 for `ADD` 2+2 → `rsp_err`=1 with `rsp_c`=0.
- Mid-operation reset: assert `rst` during WAIT with 2 entries queued → after release, no `rsp_valid`, `cmd_ready`=1, and the next command completes normally.
